// File: rtl/obstacle_pixel_locator.sv
// Per-pixel obstacle lookup: a double-buffered per-frame obstacle table feeds a 2-stage pixel pipeline.
// Optional obstacle_edge output is enabled with `define OBSTACLE_EDGE_EN.
module obstacle_pixel_locator #(
  parameter int OBSTACLE_NUM    = 8,
  parameter int OBSTACLE_WIDTH  = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int SCREEN_WIDTH    = 10,
  parameter int SCREEN_H        = 480,
  parameter int PHY_WIDTH       = 14,
  parameter int MAP_ADDR_WIDTH  = 8
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   frame_start,
  input  logic [PHY_WIDTH-1:0]                   camera_y,
  input  logic [MAP_ADDR_WIDTH-1:0]              map_base,
  input  logic [SCREEN_WIDTH-1:0]                pixel_x,
  input  logic [SCREEN_WIDTH-1:0]                pixel_y,
  input  logic                                   video_on,
  output logic                                   map_rd_en,
  output logic [MAP_ADDR_WIDTH-1:0]              map_addr,
  input  logic [2*PHY_WIDTH+BLOCK_LEN_WIDTH-1:0] map_data,
  output logic                                   table_ready,
  output logic                                   video_on_d,
  output logic                                   obstacle_on,
  output logic [SCREEN_WIDTH-1:0]                obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0]                obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]                   obstacle_block_abs_y,
  output logic [PHY_WIDTH-1:0]                   obstacle_abs_pos_y,
`ifdef OBSTACLE_EDGE_EN
  output logic                                   obstacle_edge,
`endif
  output logic [PHY_WIDTH-1:0]                   obstacle_abs_pos_x
);

  localparam int IDX_W = (OBSTACLE_NUM > 1) ? $clog2(OBSTACLE_NUM) : 1;
  localparam int CW    = PHY_WIDTH + 1;
  localparam int BLK_H = 2 * OBSTACLE_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, SWAP} state_t;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            idx;
  logic [PHY_WIDTH-1:0]        cam_y;
  logic [MAP_ADDR_WIDTH-1:0]   base;

  logic [PHY_WIDTH-1:0]        sh_x   [OBSTACLE_NUM];
  logic [PHY_WIDTH-1:0]        sh_y   [OBSTACLE_NUM];
  logic [BLOCK_LEN_WIDTH-1:0]  sh_len [OBSTACLE_NUM];
  logic [PHY_WIDTH-1:0]        act_x  [OBSTACLE_NUM];
  logic [PHY_WIDTH-1:0]        act_y  [OBSTACLE_NUM];
  logic [BLOCK_LEN_WIDTH-1:0]  act_len[OBSTACLE_NUM];

  logic [PHY_WIDTH-1:0]        rd_x, rd_y;
  logic [BLOCK_LEN_WIDTH-1:0]  rd_len;

  assign rd_x   = map_data[2*PHY_WIDTH+BLOCK_LEN_WIDTH-1 -: PHY_WIDTH];
  assign rd_y   = map_data[BLOCK_LEN_WIDTH +: PHY_WIDTH];
  assign rd_len = map_data[BLOCK_LEN_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    map_rd_en = 1'b0;
    map_addr  = '0;
    case (state)
      IDLE:  if (frame_start) state_nxt = FETCH;
      FETCH: begin
        map_rd_en = 1'b1;
        map_addr  = base + MAP_ADDR_WIDTH'(idx);
        if (frame_start)                          state_nxt = FETCH;
        else if (idx == IDX_W'(OBSTACLE_NUM - 1)) state_nxt = LAST;
      end
      LAST:  state_nxt = frame_start ? FETCH : SWAP;
      SWAP:  state_nxt = frame_start ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ROM data lags the address by one cycle, so FETCH at idx stores entry idx-1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cam_y       <= '0;
      base        <= '0;
      table_ready <= 1'b0;
      for (int i = 0; i < OBSTACLE_NUM; i++) begin
        sh_x[i]    <= '0;
        sh_y[i]    <= '0;
        sh_len[i]  <= '0;
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_len[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        idx   <= '0;
        cam_y <= camera_y;
        base  <= map_base;
      end else if (state == FETCH) begin
        idx <= idx + 1'b1;
      end
      if (state == FETCH && idx != '0) begin
        sh_x[idx - 1'b1]   <= rd_x;
        sh_y[idx - 1'b1]   <= rd_y;
        sh_len[idx - 1'b1] <= rd_len;
      end
      if (state == LAST) begin
        sh_x[OBSTACLE_NUM-1]   <= rd_x;
        sh_y[OBSTACLE_NUM-1]   <= rd_y;
        sh_len[OBSTACLE_NUM-1] <= rd_len;
      end
      if (state == SWAP) begin
        act_x       <= sh_x;
        act_y       <= sh_y;
        act_len     <= sh_len;
        table_ready <= 1'b1;
      end
    end
  end

  // ---- stage 1: register pixel and convert row to world y ----
  logic [SCREEN_WIDTH-1:0] px_p1;
  logic [PHY_WIDTH-1:0]    abs_py_p1;
  logic                    vld_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      px_p1     <= '0;
      abs_py_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      px_p1     <= pixel_x;
      abs_py_p1 <= cam_y + PHY_WIDTH'(SCREEN_H - 1) - PHY_WIDTH'(pixel_y);
      vld_p1    <= video_on;
    end
  end

  // ---- stage 2: parallel compare, lowest index wins ----
  logic [CW-1:0]           x_lo[OBSTACLE_NUM], x_hi[OBSTACLE_NUM];
  logic [CW-1:0]           y_lo[OBSTACLE_NUM], y_hi[OBSTACLE_NUM];
  logic [OBSTACLE_NUM-1:0] hit_vec;
  logic [CW-1:0]           px_w, py_w;

  assign px_w = CW'(px_p1);
  assign py_w = CW'(abs_py_p1);

  always_comb begin
    for (int i = 0; i < OBSTACLE_NUM; i++) begin
      x_lo[i]    = CW'(act_x[i]);
      x_hi[i]    = CW'(act_x[i]) + CW'(act_len[i]) * CW'(OBSTACLE_WIDTH);
      y_lo[i]    = CW'(act_y[i]);
      y_hi[i]    = CW'(act_y[i]) + CW'(BLK_H);
      hit_vec[i] = (act_len[i] != '0) && (px_w >= x_lo[i]) && (px_w < x_hi[i]) &&
                   (py_w >= y_lo[i]) && (py_w < y_hi[i]);
    end
  end

  logic                    hit_c, on_c;
  logic [SCREEN_WIDTH-1:0] x_rom_c, y_rom_c;
  logic [PHY_WIDTH-1:0]    blk_y_c, pos_x_c;
`ifdef OBSTACLE_EDGE_EN
  logic [SCREEN_WIDTH-1:0] x_last_c;
  logic                    edge_c;
`endif

  always_comb begin
    hit_c    = 1'b0;
    x_rom_c  = '0;
    y_rom_c  = '0;
    blk_y_c  = '0;
    pos_x_c  = '0;
`ifdef OBSTACLE_EDGE_EN
    x_last_c = '0;
`endif
    for (int i = OBSTACLE_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_c    = 1'b1;
        x_rom_c  = SCREEN_WIDTH'(PHY_WIDTH'(px_p1) - act_x[i]);
        y_rom_c  = SCREEN_WIDTH'(act_y[i] + PHY_WIDTH'(BLK_H - 1) - abs_py_p1);
        blk_y_c  = act_y[i];
        pos_x_c  = act_x[i];
`ifdef OBSTACLE_EDGE_EN
        x_last_c = SCREEN_WIDTH'(CW'(act_len[i]) * CW'(OBSTACLE_WIDTH) - CW'(1));
`endif
      end
    end
    on_c = hit_c & vld_p1 & table_ready;
  end

`ifdef OBSTACLE_EDGE_EN
  assign edge_c = on_c && (x_rom_c == '0 || x_rom_c == x_last_c ||
                           y_rom_c == '0 || y_rom_c == SCREEN_WIDTH'(BLK_H - 1));
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      video_on_d           <= 1'b0;
      obstacle_on          <= 1'b0;
      obstacle_x_rom       <= '0;
      obstacle_y_rom       <= '0;
      obstacle_block_abs_y <= '0;
      obstacle_abs_pos_x   <= '0;
      obstacle_abs_pos_y   <= '0;
`ifdef OBSTACLE_EDGE_EN
      obstacle_edge        <= 1'b0;
`endif
    end else begin
      video_on_d           <= vld_p1;
      obstacle_on          <= on_c;
      obstacle_x_rom       <= on_c ? x_rom_c : '0;
      obstacle_y_rom       <= on_c ? y_rom_c : '0;
      obstacle_block_abs_y <= on_c ? blk_y_c : '0;
      obstacle_abs_pos_x   <= on_c ? pos_x_c : '0;
      obstacle_abs_pos_y   <= abs_py_p1;
`ifdef OBSTACLE_EDGE_EN
      obstacle_edge        <= edge_c;
`endif
    end
  end

endmodule

// File: doc/obstacle_pixel_locator.md
Name: obstacle_pixel_locator

Overview:
- Per-pixel stage directly upstream of obstacle_display_controller.
- Once per frame, fetches the current level's obstacle list from the map ROM into a shadow table, then swaps it into an active table.
- For every VGA pixel, resolves which obstacle (if any) covers it and produces obstacle_on, the ROM coordinates and the absolute-position fields the display controller consumes.
- 2-cycle pipelined, one clock domain.

Parameters:
- OBSTACLE_NUM, 8, number of obstacle entries per level (power of two).
- OBSTACLE_WIDTH, 10, block width in pixels; block height is 2*OBSTACLE_WIDTH.
- BLOCK_LEN_WIDTH, 4, width of per-entry length in blocks (max 15).
- SCREEN_WIDTH, 10, width of screen coordinates.
- SCREEN_H, 480, visible lines.
- PHY_WIDTH, 14, width of absolute world coordinates.
- MAP_ADDR_WIDTH, 8, map ROM address width.

Ports:
- sys_clk  in  1  pixel clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- camera_y  in  PHY_WIDTH  world y of the screen bottom line; sampled on frame_start.
- map_base  in  MAP_ADDR_WIDTH  first map entry of the current level; sampled on frame_start.
- pixel_x  in  SCREEN_WIDTH  current pixel column.
- pixel_y  in  SCREEN_WIDTH  current pixel row.
- video_on  in  1  pixel is in the visible area.
- map_rd_en  out  1  map ROM read strobe.
- map_addr  out  MAP_ADDR_WIDTH  map ROM address.
- map_data  in  2*PHY_WIDTH+BLOCK_LEN_WIDTH  entry {abs_x, abs_y, len}; valid 1 cycle after map_rd_en.
- table_ready  out  1  active table is valid.
- video_on_d  out  1  video_on delayed 2 cycles.
- obstacle_on  out  1  pixel is covered by an obstacle.
- obstacle_x_rom  out  SCREEN_WIDTH  x offset inside the obstacle, 0..len*OBSTACLE_WIDTH-1.
- obstacle_y_rom  out  SCREEN_WIDTH  row inside the obstacle, 0 = top, 0..2*OBSTACLE_WIDTH-1.
- obstacle_block_abs_y  out  PHY_WIDTH  world y of the obstacle bottom (entry abs_y).
- obstacle_abs_pos_y  out  PHY_WIDTH  world y of the current pixel.
- obstacle_abs_pos_x  out  PHY_WIDTH  entry abs_x.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; both tables cleared (len=0); sampled camera_y and map_base = 0.
- Fetch FSM:
  - IDLE: frame_start -> FETCH with idx=0; camera_y and map_base latched.
  - FETCH: map_rd_en=1, map_addr=map_base+idx (modulo 2^MAP_ADDR_WIDTH). Data returned for idx-1 is written to the shadow table. idx increments each cycle; after idx=OBSTACLE_NUM-1 -> LAST.
  - LAST: write the final entry -> SWAP.
  - SWAP: shadow copied to active in one cycle; table_ready=1 from the next cycle -> IDLE.
  - Fetch takes OBSTACLE_NUM+2 cycles and always finishes inside vblank.
- frame_start while in FETCH/LAST: restart at idx=0 with the new samples. The active table is untouched and table_ready stays at its prior value.
- Reset mid-fetch: everything returns to the reset state and table_ready=0.
- Pixel pipeline:
  - Stage 1 registers pixel_x, pixel_y, video_on and abs_py = cam_y_latched + (SCREEN_H-1-pixel_y), truncated to PHY_WIDTH (wraps).
  - Stage 2 compares against all active entries in parallel. Entry i hits when len!=0, abs_x <= px < abs_x+len*OBSTACLE_WIDTH, and abs_y <= abs_py < abs_y+2*OBSTACLE_WIDTH. Compares use PHY_WIDTH+1 bits so the upper bounds do not overflow.
  - Lowest-index hit wins. On a win: x_rom = px-abs_x; y_rom = abs_y+2*OBSTACLE_WIDTH-1-abs_py; block_abs_y = abs_y; abs_pos_x = abs_x.
  - obstacle_abs_pos_y = abs_py on every cycle.
- obstacle_on = hit & video_on_s1 & table_ready. When it is 0, x_rom, y_rom, block_abs_y and abs_pos_x are 0.
- Total latency is 2 cycles from pixel_x/pixel_y to all outputs, aligned with video_on_d.

Optional Feature:
- Macro OBSTACLE_EDGE_EN.
- Defined: adds output obstacle_edge (1 bit, same latency), high when obstacle_on and (x_rom==0, x_rom==len*OBSTACLE_WIDTH-1, y_rom==0 or y_rom==2*OBSTACLE_WIDTH-1). Reset value 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then frame_start with map_base=0x10 -> map_addr steps 0x10..0x17 on 8 consecutive cycles with map_rd_en=1; table_ready rises 10 cycles after frame_start.
- Single entry {abs_x=100, abs_y=50, len=3}, camera_y=0 -> pixel (100,429) gives obstacle_on=1, x_rom=0, y_rom=19, block_abs_y=50, 2 cycles later. Pixel (130,429) gives obstacle_on=0. Pixel (129,410) gives x_rom=29, y_rom=0.
- Overlapping entries 2 and 5 both cover the pixel -> fields come from entry 2. With entry 2's len set to 0 on the next frame -> fields come from entry 5.
- frame_start re-pulsed at fetch cycle 4 -> fetch restarts at map_base, active table unchanged, obstacle_on outputs for old entries persist until the new SWAP.
- Assert sys_rst_n=0 mid-FETCH -> immediately table_ready=0 and obstacle_on=0. Next frame fetch completes normally.
- With OBSTACLE_EDGE_EN: entry {100,50,1}, pixels (100,429) and (105,420) -> obstacle_edge=1 and 0 respectively.
